// File: rtl/shift_pkg.sv
// shift_pkg: shared FSM state encoding and constants for the sequential right shifter
package shift_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int STEP = 4;
endpackage

// File: rtl/sra_step.sv
// sra_step: one combinational right-shift step with fill insertion; wide step enabled by SHIFT_RIGHT_STEP4_EN
module sra_step import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             fill_i,
  input  logic             step4_i,
  output logic [WIDTH-1:0] shifted_o
);
`ifdef SHIFT_RIGHT_STEP4_EN
  assign shifted_o = step4_i ? {{STEP{fill_i}}, value_i[WIDTH-1:STEP]} : {fill_i, value_i[WIDTH-1:1]};
`else
  logic unused_step4;
  assign unused_step4 = step4_i;
  assign shifted_o = {fill_i, value_i[WIDTH-1:1]};
`endif
endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle logical/arithmetic right shifter with valid/ready handshake; SHIFT_RIGHT_STEP4_EN adds 4-bit steps
module shift_right_seq import shift_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, shifted;
  logic [SHW-1:0]   cnt_q, cnt_d, dec;
  logic             fill_q, fill_d, step4;

`ifdef SHIFT_RIGHT_STEP4_EN
  assign step4 = int'(cnt_q) >= STEP;
`else
  assign step4 = 1'b0;
`endif
  assign dec = step4 ? SHW'(STEP) : SHW'(1);

  sra_step #(.WIDTH(WIDTH)) u_step (
    .value_i  (sh_q),
    .fill_i   (fill_q),
    .step4_i  (step4),
    .shifted_o(shifted)
  );

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = sh_q;

  // next state: capture in IDLE, step while BUSY, wait for consumer in DONE
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sh_d    = operand;
        cnt_d   = shamt;
        fill_d  = arith & operand[WIDTH-1];
        state_d = shamt == '0 ? DONE : BUSY;
      end
      BUSY: begin
        sh_d    = shifted;
        cnt_d   = cnt_q - dec;
        state_d = cnt_q == dec ? DONE : BUSY;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset discards any in-flight operation
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed and random scoreboard bench for shift_right_seq
module tb_shift_right_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] operand = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  shift_right_seq dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand  (operand),
    .shamt    (shamt),
    .arith    (arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] op, input logic [4:0] sh, input logic ar);
    logic signed [31:0] s;
    s = op;
    if (ar) return s >>> sh;
    return op >> sh;
  endfunction

  function automatic int lat(input logic [4:0] sh);
`ifdef SHIFT_RIGHT_STEP4_EN
    return int'(sh) / 4 + int'(sh) % 4;
`else
    return int'(sh);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] op, input logic [4:0] sh, input logic ar);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    operand  = op;
    shamt    = sh;
    arith    = ar;
    in_valid = 1'b1;
    exp_q.push_back(model(op, sh, ar));
    lat_q.push_back(lat(sh));
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input bit pulse);
    int n;
    logic [31:0] r;
    n = 0;
    while (!out_valid && n < 200) begin
      cyc();
      n++;
    end
    chk("latency", 32'(n), 32'(lat_q.pop_front()));
    chk("result", result, exp_q.pop_front());
    r = result;
    for (int k = 0; k < hold; k++) begin
      if (pulse) begin
        in_valid = 1'b1;
        operand  = $urandom;
        shamt    = 5'($urandom_range(0, 31));
        arith    = 1'($urandom_range(0, 1));
      end
      cyc();
      chk("hold_result", result, r);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    send(32'h8000_0000, 5'd4, 1'b1);  collect(0, 0);
    send(32'h8000_0000, 5'd4, 1'b0);  collect(1, 0);
    send(32'h7FFF_FFFF, 5'd4, 1'b1);  collect(0, 0);
    send(32'h1234_5678, 5'd0, 1'b1);  collect(2, 0);
    send(32'h8000_0000, 5'd31, 1'b1); collect(0, 0);
    send(32'h8000_0000, 5'd31, 1'b0); collect(0, 0);
    send(32'hA5A5_0F0F, 5'd3, 1'b0);  collect(5, 1);
    send(32'h8000_0000, 5'd20, 1'b1);
    cyc();
    cyc();
    chk("busy_intermediate", result, 32'hE000_0000);
    chk("busy_out_valid", 32'(out_valid), 32'd0);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", result, 32'd0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    send(32'hF000_0000, 5'd8, 1'b1);  collect(0, 0);
    for (int i = 0; i < 100; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      collect($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
